// File: rtl/condiciona_botoes_pkg.sv
`default_nettype none
// ============================================================================
// Module : condiciona_botoes_pkg
// Brief  : Shared game constants: button-conditioner FSM state codes,
//          default debounce length and a one-hot helper.
// Rev    : 1.0 - initial release
// ============================================================================
package condiciona_botoes_pkg;

   localparam int NUM_BOTOES             = 4;
   localparam int DEBOUNCE_CICLOS_PADRAO = 50000;

   // State codes are shown directly on the hexa7seg debug display
   typedef enum logic [3:0] {
      OCIOSO         = 4'd0,
      FILTRA_PRESSAO = 4'd1,
      PRESSIONADO    = 4'd2,
      FILTRA_SOLTURA = 4'd3,
      INVALIDO       = 4'd4
   } estado_t;

   // True when exactly one button is pressed
   function automatic logic eh_one_hot(input logic [NUM_BOTOES-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

endpackage : condiciona_botoes_pkg
`default_nettype wire

// File: rtl/sincronizador_2ff.sv
`default_nettype none
// ============================================================================
// Module : sincronizador_2ff
// Brief  : Two flip-flop synchronizer for asynchronous button levels.
// Rev    : 1.0 - initial release
// ============================================================================
module sincronizador_2ff #(
   parameter int LARGURA = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [LARGURA-1:0] d,
   output logic [LARGURA-1:0] q
);

   logic [LARGURA-1:0] meta_q;
   logic [LARGURA-1:0] sinc_q;

   // First stage may go metastable; second stage gives it a cycle to settle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta_q <= '0;
         sinc_q <= '0;
      end else begin
         meta_q <= d;
         sinc_q <= meta_q;
      end
   end

   assign q = sinc_q;

endmodule : sincronizador_2ff
`default_nettype wire

// File: rtl/condiciona_botoes.sv
`default_nettype none
// ============================================================================
// Module : condiciona_botoes
// Brief  : Synchronizes and debounces the four game buttons, producing a
//          held one-hot jogada plus single-cycle accept / invalid pulses.
// Rev    : 1.0 - initial release
// ============================================================================
module condiciona_botoes
   import condiciona_botoes_pkg::*;
#(
   parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_BOTOES-1:0] botoes,
   output logic [NUM_BOTOES-1:0] jogada,
   output logic                  jogada_feita,
   output logic                  botao_invalido,
   output logic [3:0]            db_estado,
   output logic [NUM_BOTOES-1:0] db_botoes_estaveis
);

   localparam int              CW     = $clog2(DEBOUNCE_CICLOS);
   localparam logic [CW-1:0]   ULTIMO = CW'(DEBOUNCE_CICLOS - 1);

   logic [NUM_BOTOES-1:0] sinc;

   estado_t               estado_q,         estado_d;
   logic [CW-1:0]         cnt_q,            cnt_d;
   logic [NUM_BOTOES-1:0] candidato_q,      candidato_d;
   logic [NUM_BOTOES-1:0] jogada_q,         jogada_d;
   logic                  jogada_feita_q,   jogada_feita_d;
   logic                  botao_invalido_q, botao_invalido_d;

   sincronizador_2ff #(
      .LARGURA (NUM_BOTOES)
   ) u_sinc (
      .clock (clock),
      .reset (reset),
      .d     (botoes),
      .q     (sinc)
   );

   // Next-state logic; the counter is cleared on every state change and
   // stops at ULTIMO because reaching it always leaves the filter state
   always_comb begin
      estado_d         = estado_q;
      cnt_d            = cnt_q;
      candidato_d      = candidato_q;
      jogada_d         = jogada_q;
      jogada_feita_d   = 1'b0;
      botao_invalido_d = 1'b0;
      case (estado_q)
         OCIOSO: begin
            if (sinc != '0) begin
               candidato_d = sinc;
               cnt_d       = '0;
               estado_d    = FILTRA_PRESSAO;
            end
         end
         FILTRA_PRESSAO: begin
            if (sinc == '0) begin
               cnt_d    = '0;
               estado_d = OCIOSO;
            end else if (sinc != candidato_q) begin
               candidato_d = sinc;
               cnt_d       = '0;
            end else if (cnt_q == ULTIMO) begin
               cnt_d = '0;
               if (eh_one_hot(candidato_q)) begin
                  jogada_d       = candidato_q;
                  jogada_feita_d = 1'b1;
                  estado_d       = PRESSIONADO;
               end else begin
                  botao_invalido_d = 1'b1;
                  estado_d         = INVALIDO;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSIONADO, INVALIDO: begin
            if (sinc == '0) begin
               cnt_d    = '0;
               estado_d = FILTRA_SOLTURA;
            end
         end
         FILTRA_SOLTURA: begin
            if (sinc != '0) begin
               cnt_d    = '0;
               estado_d = PRESSIONADO;
            end else if (cnt_q == ULTIMO) begin
               cnt_d    = '0;
               estado_d = OCIOSO;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            cnt_d    = '0;
            estado_d = OCIOSO;
         end
      endcase
   end

   // State and registered outputs; reset clears everything asynchronously
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q         <= OCIOSO;
         cnt_q            <= '0;
         candidato_q      <= '0;
         jogada_q         <= '0;
         jogada_feita_q   <= 1'b0;
         botao_invalido_q <= 1'b0;
      end else begin
         estado_q         <= estado_d;
         cnt_q            <= cnt_d;
         candidato_q      <= candidato_d;
         jogada_q         <= jogada_d;
         jogada_feita_q   <= jogada_feita_d;
         botao_invalido_q <= botao_invalido_d;
      end
   end

   assign jogada             = jogada_q;
   assign jogada_feita       = jogada_feita_q;
   assign botao_invalido     = botao_invalido_q;
   assign db_estado          = estado_q;
   assign db_botoes_estaveis = sinc;

endmodule : condiciona_botoes
`default_nettype wire

// File: tb/tb_condiciona_botoes.sv
`default_nettype none
// ============================================================================
// Module : tb_condiciona_botoes
// Brief  : Scoreboard bench for condiciona_botoes with DEBOUNCE_CICLOS=4.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_condiciona_botoes;

   logic       clk;
   logic       reset;
   logic [3:0] botoes;
   logic [3:0] jogada;
   logic       jogada_feita;
   logic       botao_invalido;
   logic [3:0] db_estado;
   logic [3:0] db_botoes_estaveis;

   typedef struct {
      bit         inv;
      logic [3:0] jog;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   passes = 0;

   condiciona_botoes #(
      .DEBOUNCE_CICLOS (4)
   ) dut (
      .clock              (clk),
      .reset              (reset),
      .botoes             (botoes),
      .jogada             (jogada),
      .jogada_feita       (jogada_feita),
      .botao_invalido     (botao_invalido),
      .db_estado          (db_estado),
      .db_botoes_estaveis (db_botoes_estaveis)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter: value seen at a negedge is the number of posedges so far
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nome, input logic [31:0] atual,
                        input logic [31:0] esperado);
      checks++;
      if (atual === esperado) passes++;
      else $display("FAIL %s: got %0h expected %0h (cyc %0d)", nome, atual, esperado, cyc);
   endtask

   task automatic espera(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic espera_pulso(input bit inv, input logic [3:0] jog, input int c);
      exp_t e;
      e.inv = inv;
      e.jog = jog;
      e.cyc = c;
      sb.push_back(e);
   endtask

   // Monitor: every output pulse is matched against the oldest expectation
   always @(negedge clk) begin
      if (jogada_feita || botao_invalido) begin
         check("exclusao", {31'd0, jogada_feita & botao_invalido}, 32'd0);
         if (sb.size() == 0) begin
            checks++;
            $display("FAIL pulso_inesperado: jf=%0b inv=%0b jogada=%0h cyc %0d",
                     jogada_feita, botao_invalido, jogada, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("tipo_pulso", {31'd0, botao_invalido}, {31'd0, e.inv});
            check("jogada_pulso", {28'd0, jogada}, {28'd0, e.jog});
            check("ciclo_pulso", cyc, e.cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int h;
      int r;
      reset  = 1'b0;
      botoes = 4'b0101;
      espera(3);
      check("rst_jogada", {28'd0, jogada}, 32'd0);
      check("rst_jf", {31'd0, jogada_feita}, 32'd0);
      check("rst_inv", {31'd0, botao_invalido}, 32'd0);
      check("rst_estado", {28'd0, db_estado}, 32'd0);
      check("rst_estaveis", {28'd0, db_botoes_estaveis}, 32'd0);
      botoes = 4'b0000;
      espera(1);
      reset = 1'b1;
      espera(3);

      // Clean press
      s = cyc;
      botoes = 4'b0010;
      espera_pulso(1'b0, 4'b0010, s + 7);
      espera(2);
      check("limpo_estado0", {28'd0, db_estado}, 32'd0);
      check("limpo_estaveis", {28'd0, db_botoes_estaveis}, 32'h2);
      espera(1);
      check("limpo_estado1", {28'd0, db_estado}, 32'd1);
      espera(4);
      check("limpo_estado2", {28'd0, db_estado}, 32'd2);
      check("limpo_jogada", {28'd0, jogada}, 32'h2);
      espera(13);
      botoes = 4'b0000;
      espera(12);
      check("limpo_ocioso", {28'd0, db_estado}, 32'd0);
      check("limpo_mantem", {28'd0, jogada}, 32'h2);

      // Press bounce
      botoes = 4'b0100; espera(1);
      botoes = 4'b0000; espera(1);
      botoes = 4'b0100; espera(1);
      botoes = 4'b0000; espera(1);
      h = cyc;
      check("quique_ocioso", {28'd0, db_estado}, 32'd0);
      botoes = 4'b0100;
      espera_pulso(1'b0, 4'b0100, h + 7);
      espera(8);
      check("quique_jogada", {28'd0, jogada}, 32'h4);
      espera(10);
      botoes = 4'b0000;
      espera(12);

      // Invalid press keeps previous jogada
      s = cyc;
      botoes = 4'b0011;
      espera_pulso(1'b1, 4'b0100, s + 7);
      espera(8);
      check("invalido_estado", {28'd0, db_estado}, 32'd4);
      check("invalido_jogada", {28'd0, jogada}, 32'h4);
      espera(5);
      botoes = 4'b0000;
      espera(12);
      check("invalido_ocioso", {28'd0, db_estado}, 32'd0);

      // Release bounce
      s = cyc;
      botoes = 4'b1000;
      espera_pulso(1'b0, 4'b1000, s + 7);
      espera(10);
      check("soltura_press", {28'd0, db_estado}, 32'd2);
      r = cyc;
      botoes = 4'b0000; espera(1);
      botoes = 4'b1000; espera(1);
      botoes = 4'b0000;
      espera(1);
      check("soltura_filtra", {28'd0, db_estado}, 32'd3);
      espera(1);
      check("soltura_volta", {28'd0, db_estado}, 32'd2);
      espera(4);
      check("soltura_filtra2", {28'd0, db_estado}, 32'd3);
      espera(1);
      check("soltura_ocioso", {28'd0, db_estado}, 32'd0);
      check("soltura_jogada", {28'd0, jogada}, 32'h8);
      check("soltura_ciclo", cyc, r + 9);

      // Candidate change during filtering
      s = cyc;
      botoes = 4'b0001;
      espera(2);
      botoes = 4'b0100;
      espera_pulso(1'b0, 4'b0100, s + 9);
      espera(15);
      botoes = 4'b0000;
      espera(12);

      // Asynchronous reset during the accept pulse, button kept held
      botoes = 4'b0010;
      espera(6);
      @(posedge clk);
      #1;
      check("rst_async_pulso", {31'd0, jogada_feita}, 32'd1);
      check("rst_async_jog0", {28'd0, jogada}, 32'h2);
      reset = 1'b0;
      #1;
      check("rst_async_jf", {31'd0, jogada_feita}, 32'd0);
      check("rst_async_jogada", {28'd0, jogada}, 32'd0);
      check("rst_async_estado", {28'd0, db_estado}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      r = cyc;
      espera_pulso(1'b0, 4'b0010, r + 7);
      espera(12);
      botoes = 4'b0000;
      espera(12);

      check("fila_vazia", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule : tb_condiciona_botoes
`default_nettype wire
